dram_host_loader: RTL and testbench

//  Host-side front end for the 8-bit data RAM. Loads a byte stream from the host into DRAM,

---
 rtl/dram_host_loader_pkg.sv | 16 +
 rtl/dram_port_mux.sv | 32 +++
 rtl/dram_host_loader.sv | 131 +++++++++++++
 tb/tb_dram_host_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dram_host_loader_pkg.sv
// rtl/dram_host_loader_pkg.sv - shared types for the host-side DRAM loader
package dram_host_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DUMP_RD = 3'd3,
    ST_DUMP_TX = 3'd4
  } loader_state_t;

  function automatic logic owner_is_proc(loader_state_t st);
    return st == ST_RUN;
  endfunction

endpackage

// File: rtl/dram_port_mux.sv
// rtl/dram_port_mux.sv - DRAM port owner select between loader/dump logic and processor
module dram_port_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel_proc,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_wdata,
  input  logic             ld_we,
  input  logic [WIDTH-1:0] proc_addr,
  input  logic [WIDTH-1:0] proc_wdata,
  input  logic             proc_wr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] proc_rdata
);

  always_comb begin
    mem_addr   = ld_addr;
    mem_wdata  = ld_wdata;
    mem_we     = ld_we;
    proc_rdata = '0;
    if (sel_proc) begin
      mem_addr   = proc_addr;
      mem_wdata  = proc_wdata;
      mem_we     = proc_wr;
      proc_rdata = mem_rdata;
    end
  end

endmodule

// File: rtl/dram_host_loader.sv
// rtl/dram_host_loader.sv - loads host bytes into DRAM, runs the processor, dumps a result window
module dram_host_loader
  import dram_host_loader_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] DUMP_BASE = 8'h80,
  parameter int               DUMP_LEN  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  output logic             proc_en,
  input  logic             proc_halt,
  input  logic [WIDTH-1:0] proc_addr,
  input  logic [WIDTH-1:0] proc_wdata,
  input  logic             proc_rd,
  input  logic             proc_wr,
  output logic [WIDTH-1:0] proc_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DUMP_LEN - 1);

  loader_state_t    state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] len, len_nxt;
  logic [WIDTH-1:0] tx_hold;
  logic             tx_fresh;
  logic [WIDTH-1:0] ld_addr, ld_wdata;
  logic             ld_we;
  logic             unused_proc_rd;

  // Reads are free-running on the RAM, so the processor read strobe carries no information here.
  assign unused_proc_rd = proc_rd;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      len      <= '0;
      tx_hold  <= '0;
      tx_fresh <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      len      <= len_nxt;
      tx_fresh <= (state_nxt == ST_DUMP_TX) && (state != ST_DUMP_TX);
      if (tx_fresh) tx_hold <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    rx_ready  = 1'b0;
    ld_addr   = '0;
    ld_wdata  = '0;
    ld_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_nxt   = rx_data;
          count_nxt = '0;
          state_nxt = (rx_data == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        rx_ready = 1'b1;
        ld_addr  = count;
        ld_wdata = rx_data;
        // A write racing a reset must not land in the RAM.
        ld_we    = rx_valid && !Rst;
        if (rx_valid) begin
          count_nxt = count + WIDTH'(1);
          if (count == len - WIDTH'(1)) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (proc_halt) begin
          count_nxt = '0;
          state_nxt = ST_DUMP_RD;
        end
      end
      ST_DUMP_RD: begin
        ld_addr   = DUMP_BASE + count;
        state_nxt = ST_DUMP_TX;
      end
      ST_DUMP_TX: begin
        ld_addr = DUMP_BASE + count;
        if (tx_ready) begin
          count_nxt = count + WIDTH'(1);
          state_nxt = (count == LAST_IDX) ? ST_IDLE : ST_DUMP_RD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign proc_en  = (state == ST_RUN);
  assign busy     = (state != ST_IDLE);
  assign tx_valid = (state == ST_DUMP_TX);
  // First TX cycle shows the fresh RAM output; afterwards the captured copy keeps it stable.
  assign tx_data  = (state != ST_DUMP_TX) ? '0 : (tx_fresh ? mem_rdata : tx_hold);

  dram_port_mux #(.WIDTH(WIDTH)) u_port_mux (
    .sel_proc  (owner_is_proc(state)),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_we     (ld_we),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_wr   (proc_wr),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .proc_rdata(proc_rdata)
  );

endmodule

// File: tb/tb_dram_host_loader.sv
// tb/tb_dram_host_loader.sv - directed self-checking bench for dram_host_loader
module tb_dram_host_loader;

  logic       Clk, Rst;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic       proc_en, proc_halt, proc_rd, proc_wr, mem_we, busy;
  logic [7:0] proc_addr, proc_wdata, proc_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       ram_clear;
  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  dram_host_loader #(.WIDTH(8), .DUMP_BASE(8'h80), .DUMP_LEN(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .proc_en(proc_en), .proc_halt(proc_halt),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rd(proc_rd), .proc_wr(proc_wr), .proc_rdata(proc_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Synchronous RAM, read-before-write; result window preset to 00..0F.
  always @(posedge Clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= (i >= 8'h80 && i < 8'h90) ? 8'(i - 8'h80) : 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       proc_wr;
    logic       proc_rd;
    logic [7:0] proc_addr;
    logic [7:0] proc_wdata;
    logic       e_rx_ready;
    logic       e_mem_we;
    logic [7:0] e_mem_addr;
    logic [7:0] e_mem_wdata;
    logic [7:0] e_proc_rdata;
    logic       e_proc_en;
    logic       e_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int idx;
    bit done;
    //             rxv  rxd    wr    rd    paddr  pwdata  rdy  we   maddr  mwdata prdata en    busy
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 8'hBB, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hCC, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'hCC, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h85, 8'h5A, 1'b0, 1'b1, 8'h85, 8'h5A, 8'hAA, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h85, 8'h00, 1'b0, 1'b0, 8'h85, 8'h00, 8'h05, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h85, 8'h05, 1'b0, 1'b1, 8'h85, 8'h05, 8'h5A, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b1};

    Rst = 1'b1; ram_clear = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    proc_halt = 1'b0; proc_addr = 8'h00; proc_wdata = 8'h00; proc_rd = 1'b0; proc_wr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset tx_valid", 8'(tx_valid), 8'h00);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset proc_en", 8'(proc_en), 8'h00);
    chk("reset busy", 8'(busy), 8'h00);
    chk("reset rx_ready", 8'(rx_ready), 8'h01);

    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      Rst = 1'b0; ram_clear = 1'b0;
      rx_valid = vecs[i].rx_valid; rx_data = vecs[i].rx_data;
      proc_wr = vecs[i].proc_wr; proc_rd = vecs[i].proc_rd;
      proc_addr = vecs[i].proc_addr; proc_wdata = vecs[i].proc_wdata;
      #1;
      chk($sformatf("v%0d rx_ready", i), 8'(rx_ready), 8'(vecs[i].e_rx_ready));
      chk($sformatf("v%0d mem_we", i), 8'(mem_we), 8'(vecs[i].e_mem_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      chk($sformatf("v%0d proc_rdata", i), proc_rdata, vecs[i].e_proc_rdata);
      chk($sformatf("v%0d proc_en", i), 8'(proc_en), 8'(vecs[i].e_proc_en));
      chk($sformatf("v%0d busy", i), 8'(busy), 8'(vecs[i].e_busy));
    end
    chk("ram[00]", ram[0], 8'hAA);
    chk("ram[01]", ram[1], 8'hBB);
    chk("ram[02]", ram[2], 8'hCC);
    chk("ram[03] untouched in run", ram[3], 8'h00);
    chk("ram[85] restored", ram[8'h85], 8'h05);

    // Halt and dump with a toggling host ready.
    @(negedge Clk);
    rx_valid = 1'b0; proc_halt = 1'b1;
    #1 chk("halt cycle proc_en", 8'(proc_en), 8'h01);
    @(negedge Clk);
    #1;
    chk("after halt proc_en", 8'(proc_en), 8'h00);
    chk("dump_rd tx_valid", 8'(tx_valid), 8'h00);
    chk("dump_rd mem_addr", mem_addr, 8'h80);
    idx = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge Clk);
      proc_halt = 1'b0;
      tx_ready = cyc[0];
      #1;
      if (tx_valid) begin
        chk($sformatf("dump byte %0d", idx), tx_data, 8'(idx));
        if (tx_ready) begin
          idx++;
          if (idx == 16) done = 1;
        end
      end
    end
    chk("dump bytes received", 8'(idx), 8'd16);
    @(negedge Clk);
    tx_ready = 1'b0;
    #1;
    chk("post dump busy", 8'(busy), 8'h00);
    chk("post dump tx_valid", 8'(tx_valid), 8'h00);
    chk("post dump tx_data", tx_data, 8'h00);

    // Reset in the middle of a load.
    @(negedge Clk);
    rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge Clk);
    rx_data = 8'hAA;
    #1 chk("midload mem_we", 8'(mem_we), 8'h01);
    @(negedge Clk);
    Rst = 1'b1; rx_data = 8'hDD;
    #1 chk("reset cycle mem_we", 8'(mem_we), 8'h00);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0; rx_valid = 1'b0;
    #1;
    chk("after reset busy", 8'(busy), 8'h00);
    chk("after reset mem_we", 8'(mem_we), 8'h00);
    chk("after reset proc_en", 8'(proc_en), 8'h00);
    chk("after reset tx_valid", 8'(tx_valid), 8'h00);
    chk("after reset rx_ready", 8'(rx_ready), 8'h01);
    chk("ram[01] not overwritten", ram[1], 8'hBB);

    // Zero-length load goes straight to run.
    @(negedge Clk);
    rx_valid = 1'b1; rx_data = 8'h00;
    #1 chk("len0 mem_we", 8'(mem_we), 8'h00);
    @(negedge Clk);
    rx_valid = 1'b0;
    #1;
    chk("len0 proc_en", 8'(proc_en), 8'h01);
    chk("len0 run mem_we", 8'(mem_we), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
